// File: rtl/lemming_pkg.sv
// Shared types and constants for the lemming terrain model.
package lemming_pkg;

    localparam int DEPTH_W     = 3;
    localparam int SPLAT_LIMIT = 20;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_FALL,
        ACT_DIG,
        ACT_LEFT,
        ACT_RIGHT
    } act_e;

endpackage

// File: rtl/terrain_floor_mem.sv
// Per-column floor depth register file: async read, one write port (cfg write, else dig increment).
module terrain_floor_mem
    import lemming_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic [POS_W-1:0]   rd_addr,
    output logic [DEPTH_W-1:0] rd_data,
    input  logic               cfg_we,
    input  logic [POS_W-1:0]   cfg_col,
    input  logic [DEPTH_W-1:0] cfg_data,
    input  logic               inc_en
);

    logic [DEPTH_W-1:0] mem_q [WIDTH];

    assign rd_data = mem_q[rd_addr];

    // NOTE: this array is a register file, not a RAM macro, so every cell is cleared on reset.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cfg_we) begin
            mem_q[cfg_col] <= cfg_data;
        end else if (inc_en) begin
            mem_q[rd_addr] <= rd_data + 1'b1;
        end
    end

endmodule

// File: rtl/lemming_terrain.sv
// Terrain environment for the lemming walker: position, depth, diggable floor map, Moore outputs.
// Optional SPLAT_MONITOR_EN adds a sticky splat output driven by a saturating fall counter.
module lemming_terrain
    import lemming_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int MAX_DEPTH  = 7,
    parameter  int DIG_CYCLES = 4,
    parameter  int START_POS  = 0,
    localparam int POS_W      = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic               walk_left,
    input  logic               walk_right,
    input  logic               aaah,
    input  logic               digging,
    input  logic               dig_cmd,
    input  logic               cfg_we,
    input  logic [POS_W-1:0]   cfg_col,
    input  logic [DEPTH_W-1:0] cfg_floor,
    output logic               ground,
    output logic               bump_left,
    output logic               bump_right,
    output logic               dig,
    output logic [POS_W-1:0]   pos,
    output logic [DEPTH_W-1:0] height
`ifdef SPLAT_MONITOR_EN
    ,
    output logic               splat
`endif
);

    localparam int CNT_W = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

    logic [POS_W-1:0]   pos_q, pos_d;
    logic [DEPTH_W-1:0] height_q, height_d;
    logic [CNT_W-1:0]   dig_cnt_q, dig_cnt_d;
    logic               dig_q;
    logic [DEPTH_W-1:0] floor_at_pos;
    logic [DEPTH_W-1:0] cfg_floor_clamped;
    logic               dig_done;
    act_e               act;

    terrain_floor_mem #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_floor (
        .clk      (clk),
        .areset_n (areset_n),
        .rd_addr  (pos_q),
        .rd_data  (floor_at_pos),
        .cfg_we   (cfg_we),
        .cfg_col  (cfg_col),
        .cfg_data (cfg_floor_clamped),
        .inc_en   (dig_done)
    );

    // Outputs depend only on registered state, so the walker FSM loop has no comb path.
    assign ground     = (height_q == floor_at_pos);
    assign bump_left  = (pos_q == '0) || (height_q != '0);
    assign bump_right = (pos_q == POS_W'(WIDTH - 1)) || (height_q != '0);
    assign dig        = dig_q;
    assign pos        = pos_q;
    assign height     = height_q;

    assign cfg_floor_clamped = (cfg_floor > DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) : cfg_floor;

    always_comb begin
        if (aaah)            act = ACT_FALL;
        else if (digging)    act = ACT_DIG;
        else if (walk_left)  act = ACT_LEFT;
        else if (walk_right) act = ACT_RIGHT;
        else                 act = ACT_NONE;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        pos_d     = pos_q;
        height_d  = height_q;
        dig_cnt_d = '0;
        dig_done  = 1'b0;
        case (act)
            ACT_FALL: begin
                if (height_q < floor_at_pos) height_d = height_q + 1'b1;
            end
            ACT_DIG: begin
                if (ground && (floor_at_pos < DEPTH_W'(MAX_DEPTH))) begin
                    if (dig_cnt_q == CNT_W'(DIG_CYCLES - 1)) dig_done = 1'b1;
                    else                                     dig_cnt_d = dig_cnt_q + 1'b1;
                end
            end
            ACT_LEFT: begin
                if ((height_q == '0) && (pos_q != '0)) pos_d = pos_q - 1'b1;
            end
            ACT_RIGHT: begin
                if ((height_q == '0) && (pos_q != POS_W'(WIDTH - 1))) pos_d = pos_q + 1'b1;
            end
            default: ;
        endcase
        // Lowering the floor under the lemming lifts it back so height never exceeds floor.
        if (cfg_we && (cfg_col == pos_q) && (cfg_floor_clamped < height_d)) begin
            height_d = cfg_floor_clamped;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pos_q     <= POS_W'(START_POS);
            height_q  <= '0;
            dig_cnt_q <= '0;
            dig_q     <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            height_q  <= height_d;
            dig_cnt_q <= dig_cnt_d;
            dig_q     <= dig_cmd;
        end
    end

`ifdef SPLAT_MONITOR_EN
    logic [4:0] fall_cnt_q, fall_cnt_d;
    logic       splat_q, splat_d;

    always_comb begin
        fall_cnt_d = '0;
        splat_d    = splat_q;
        if (aaah) begin
            fall_cnt_d = (fall_cnt_q == 5'd31) ? fall_cnt_q : fall_cnt_q + 1'b1;
        end else if (ground && (fall_cnt_q > 5'(SPLAT_LIMIT))) begin
            splat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            fall_cnt_q <= '0;
            splat_q    <= 1'b0;
        end else begin
            fall_cnt_q <= fall_cnt_d;
            splat_q    <= splat_d;
        end
    end

    assign splat = splat_q;
`endif

endmodule

// File: tb/tb_lemming_terrain.sv
// Self-checking bench for lemming_terrain: directed table, multi-cycle corner sequences, random vs reference model.
`timescale 1ns/1ps
module tb_lemming_terrain;
    import lemming_pkg::*;

    localparam int WIDTH      = 16;
    localparam int MAX_DEPTH  = 7;
    localparam int DIG_CYCLES = 4;
    localparam int START_POS  = 0;
    localparam int POS_W      = 4;

    logic               clk = 1'b0;
    logic               areset_n = 1'b0;
    logic               walk_left = 0, walk_right = 0, aaah = 0, digging = 0, dig_cmd = 0, cfg_we = 0;
    logic [POS_W-1:0]   cfg_col = '0;
    logic [DEPTH_W-1:0] cfg_floor = '0;
    logic               ground, bump_left, bump_right, dig;
    logic [POS_W-1:0]   pos;
    logic [DEPTH_W-1:0] height;
`ifdef SPLAT_MONITOR_EN
    logic               splat;
`endif

    always #5 clk = ~clk;

    lemming_terrain #(
        .WIDTH      (WIDTH),
        .MAX_DEPTH  (MAX_DEPTH),
        .DIG_CYCLES (DIG_CYCLES),
        .START_POS  (START_POS)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .dig_cmd    (dig_cmd),
        .cfg_we     (cfg_we),
        .cfg_col    (cfg_col),
        .cfg_floor  (cfg_floor),
        .ground     (ground),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .dig        (dig),
        .pos        (pos),
        .height     (height)
`ifdef SPLAT_MONITOR_EN
        ,
        .splat      (splat)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integers and an array of floor depths.
    int m_floor [WIDTH];
    int m_pos, m_h, m_cnt, m_dig;

    typedef struct {
        bit wl, wr, aa, dg, cmd, we;
        int col, fl;
        int e_pos, e_h;
        bit e_g, e_bl, e_br, e_dig;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) m_floor[i] = 0;
        m_pos = START_POS;
        m_h   = 0;
        m_cnt = 0;
        m_dig = 0;
    endtask

    task automatic model_step();
        int  fl, n_pos, n_h, n_cnt, v;
        bit  inc;
        fl    = m_floor[m_pos];
        n_pos = m_pos;
        n_h   = m_h;
        n_cnt = 0;
        inc   = 0;
        if (aaah) begin
            if (m_h < fl) n_h = m_h + 1;
        end else if (digging) begin
            if (m_h == fl && fl < MAX_DEPTH) begin
                if (m_cnt + 1 == DIG_CYCLES) inc = 1;
                else n_cnt = m_cnt + 1;
            end
        end else if (walk_left) begin
            if (m_h == 0 && m_pos > 0) n_pos = m_pos - 1;
        end else if (walk_right) begin
            if (m_h == 0 && m_pos < WIDTH - 1) n_pos = m_pos + 1;
        end
        if (cfg_we) begin
            v = (int'(cfg_floor) > MAX_DEPTH) ? MAX_DEPTH : int'(cfg_floor);
            if (int'(cfg_col) == m_pos && v < n_h) n_h = v;
            m_floor[cfg_col] = v;
        end else if (inc) begin
            m_floor[m_pos] = fl + 1;
        end
        m_pos = n_pos;
        m_h   = n_h;
        m_cnt = n_cnt;
        m_dig = dig_cmd;
    endtask

    task automatic drive(input bit wl, wr, aa, dg, cmd, we, input int col, fl);
        walk_left  = wl;
        walk_right = wr;
        aaah       = aa;
        digging    = dg;
        dig_cmd    = cmd;
        cfg_we     = we;
        cfg_col    = POS_W'(col);
        cfg_floor  = DEPTH_W'(fl);
    endtask

    // One clock edge; the model sees the same inputs the DUT sampled, then outputs are read 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " pos"},    int'(pos),        m_pos);
        check({tag, " height"}, int'(height),     m_h);
        check({tag, " ground"}, int'(ground),     int'(m_h == m_floor[m_pos]));
        check({tag, " bumpl"},  int'(bump_left),  int'(m_pos == 0 || m_h > 0));
        check({tag, " bumpr"},  int'(bump_right), int'(m_pos == WIDTH - 1 || m_h > 0));
        check({tag, " dig"},    int'(dig),        m_dig);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        areset_n = 1'b0;
        model_reset();
        #2;
        check("reset pos",    int'(pos),        START_POS);
        check("reset height", int'(height),     0);
        check("reset ground", int'(ground),     1);
        check("reset bumpl",  int'(bump_left),  1);
        check("reset dig",    int'(dig),        0);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    initial begin
        vec_t tbl [17];
        tbl[0]  = '{1,0,0,0,0,0, 0,0, 0,0, 1,1,0,0};
        tbl[1]  = '{0,0,0,0,0,1, 3,2, 0,0, 1,1,0,0};
        tbl[2]  = '{0,1,0,0,0,0, 0,0, 1,0, 1,0,0,0};
        tbl[3]  = '{0,1,0,0,0,0, 0,0, 2,0, 1,0,0,0};
        tbl[4]  = '{0,1,0,0,0,0, 0,0, 3,0, 0,0,0,0};
        tbl[5]  = '{0,0,1,0,0,0, 0,0, 3,1, 0,1,1,0};
        tbl[6]  = '{0,0,1,0,0,0, 0,0, 3,2, 1,1,1,0};
        tbl[7]  = '{0,0,1,0,0,0, 0,0, 3,2, 1,1,1,0};
        tbl[8]  = '{0,1,0,0,0,0, 0,0, 3,2, 1,1,1,0};
        tbl[9]  = '{1,0,0,0,1,0, 0,0, 3,2, 1,1,1,1};
        tbl[10] = '{0,0,0,0,0,0, 0,0, 3,2, 1,1,1,0};
        tbl[11] = '{0,0,0,0,0,1, 3,0, 3,0, 1,0,0,0};
        tbl[12] = '{0,0,0,1,0,0, 0,0, 3,0, 1,0,0,0};
        tbl[13] = '{0,0,0,1,0,0, 0,0, 3,0, 1,0,0,0};
        tbl[14] = '{0,0,0,1,0,0, 0,0, 3,0, 1,0,0,0};
        tbl[15] = '{0,0,0,1,0,0, 0,0, 3,0, 0,0,0,0};
        tbl[16] = '{0,0,1,0,0,0, 0,0, 3,1, 1,1,1,0};

        #3;
        do_reset();

        // Directed table: walk to a pit, fall, get trapped, dig pulse, cfg rescue, dig through a cell.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].wl, tbl[i].wr, tbl[i].aa, tbl[i].dg, tbl[i].cmd, tbl[i].we, tbl[i].col, tbl[i].fl);
            tick();
            check($sformatf("vec%0d pos", i),    int'(pos),        tbl[i].e_pos);
            check($sformatf("vec%0d height", i), int'(height),     tbl[i].e_h);
            check($sformatf("vec%0d ground", i), int'(ground),     int'(tbl[i].e_g));
            check($sformatf("vec%0d bumpl", i),  int'(bump_left),  int'(tbl[i].e_bl));
            check($sformatf("vec%0d bumpr", i),  int'(bump_right), int'(tbl[i].e_br));
            check($sformatf("vec%0d dig", i),    int'(dig),        int'(tbl[i].e_dig));
        end

        // Walk right across the whole terrain: saturates at the right edge.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0);
            tick();
            check($sformatf("walkr%0d pos", k),   int'(pos),        (k < WIDTH - 1) ? k : WIDTH - 1);
            check($sformatf("walkr%0d bumpr", k), int'(bump_right), int'(k >= WIDTH - 1));
        end

        // Fall to depth 6, partial dig lost on interruption, then dig to bedrock.
        drive(0, 0, 0, 0, 0, 1, 15, 6);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        check("deep height", int'(height), 6);
        check("deep ground", int'(ground), 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("trapped pos", int'(pos), 15);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            tick();
        end
        check("partial lost ground", int'(ground), 1);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        check("dig7 ground", int'(ground), 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        check("bedrock height", int'(height), 7);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            tick();
            check($sformatf("bedrock%0d ground", k), int'(ground), 1);
        end

        // Reset in the middle of a dig wipes the dig progress.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            tick();
        end
        #2;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            tick();
            check($sformatf("redig%0d ground", k), int'(ground), int'(k < 4));
        end

        // Randomized closed-loop-ish stimulus against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                  ($urandom_range(0, 1) == 1) ? m_pos : int'($urandom_range(0, WIDTH - 1)),
                  int'($urandom_range(0, 7)));
            tick();
            check_model($sformatf("rnd%0d", k));
        end

`ifdef SPLAT_MONITOR_EN
        // Long fall then landing sets splat; one cycle shorter does not.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            drive(0, 0, 0, 0, 0, 1, 0, 7);
            tick();
            for (int k = 0; k < 21 - run; k++) begin
                drive(0, 0, 1, 0, 0, 0, 0, 0);
                tick();
            end
            for (int k = 0; k < 3; k++) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0);
                tick();
                check($sformatf("splat run%0d k%0d", run, k), int'(splat), int'(run == 0));
            end
        end
`endif

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
